// File: rtl/ula_multiciclo_if.sv
// ---------------------------------------------------------------------------
// ula_multiciclo_if
// Bus between the forwarding muxes / hazard unit (master) and the EX-stage
// multi-cycle ALU (slave).
//
// Signals (directions seen from the slave):
//   operandoA       in   LARGURA  forwarded rs1 value
//   operandoB       in   LARGURA  forwarded rs2 value or immediate
//   opULA           in   4        operation select
//   valido          in   1        issue strobe
//   flush           in   1        kill the in-flight op
//   resultado       out  LARGURA  registered result
//   resultadoValido out  1        one-cycle pulse, resultado is new
//   zero            out  1        registered (resultado == 0)
//   divPorZero      out  1        pulse with resultadoValido on divide by 0
//   ocupado         out  1        combinational stall request
// ---------------------------------------------------------------------------
interface ula_multiciclo_if #(
    parameter int LARGURA = 32
);
    logic [LARGURA-1:0] operandoA;
    logic [LARGURA-1:0] operandoB;
    logic [3:0]         opULA;
    logic               valido;
    logic               flush;
    logic [LARGURA-1:0] resultado;
    logic               resultadoValido;
    logic               zero;
    logic               divPorZero;
    logic               ocupado;

    modport master (
        output operandoA, operandoB, opULA, valido, flush,
        input  resultado, resultadoValido, zero, divPorZero, ocupado
    );

    modport slave (
        input  operandoA, operandoB, opULA, valido, flush,
        output resultado, resultadoValido, zero, divPorZero, ocupado
    );
endinterface

// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
// EX-stage ALU. Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT/SLL/SRL and divide
// by zero) register their result one edge after issue. MUL, DIVU and REMU
// run through a radix-2 iterative engine (shift-add multiply, restoring
// divide) and hold the pipeline through ocupado until the result is out.
//
// Ports:
//   clock    in   pipeline clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      ula_multiciclo_if.slave (operands, op, valido, flush in;
//            resultado, resultadoValido, zero, divPorZero, ocupado out)
//
// Configuration macro:
//   ULA_MULH_EN  when defined, opULA 11 is MULHU (upper half of the unsigned
//                product, multi-cycle). When undefined, opULA 11 returns 0
//                in a single cycle like opcodes 12..15.
// ---------------------------------------------------------------------------
module ula_multiciclo #(
    parameter int LARGURA = 32
) (
    input logic             clock,
    input logic             reset_n,
    ula_multiciclo_if.slave bus
);
    localparam int CW = $clog2(LARGURA) + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_REMU  = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } estado_t;

    estado_t              estado_q,     estado_d;
    logic [CW-1:0]        contador_q,   contador_d;
    // Engine register: multiply {acumulador, multiplicador},
    // divide {resto, quociente}.
    logic [2*LARGURA-1:0] acc_q,        acc_d;
    logic [LARGURA-1:0]   opB_q,        opB_d;
    logic [3:0]           opCode_q,     opCode_d;
    logic [LARGURA-1:0]   resultado_q,  resultado_d;
    logic                 resValido_q,  resValido_d;
    logic                 zero_q,       zero_d;
    logic                 divZero_q,    divZero_d;

    logic                 ehDivisao;
    logic                 bZero;
    logic                 ehMulti;
    logic                 ehMulEngine;
    logic                 aceita;
    logic [LARGURA-1:0]   unicoRes;
    logic [LARGURA-1:0]   finalRes;
    logic [LARGURA:0]     mulSoma;
    logic [2*LARGURA-1:0] mulPasso;
    logic [LARGURA:0]     divTopo;
    logic [LARGURA:0]     divTeste;
    logic [2*LARGURA-1:0] divPasso;

    // Classify the incoming op; divide by zero is resolved on the single-cycle path.
    always_comb begin
        ehDivisao = (bus.opULA == OP_DIVU) || (bus.opULA == OP_REMU);
        bZero     = (bus.operandoB == '0);
`ifdef ULA_MULH_EN
        ehMulti   = (bus.opULA == OP_MUL) || (bus.opULA == OP_MULHU) || (ehDivisao && !bZero);
`else
        ehMulti   = (bus.opULA == OP_MUL) || (ehDivisao && !bZero);
`endif
        aceita    = bus.valido && !bus.flush && (estado_q == IDLE);
    end

    // Single-cycle result; DIVU/REMU only reach here when the divisor is zero.
    always_comb begin
        unicoRes = '0;
        case (bus.opULA)
            OP_ADD:  unicoRes = bus.operandoA + bus.operandoB;
            OP_SUB:  unicoRes = bus.operandoA - bus.operandoB;
            OP_AND:  unicoRes = bus.operandoA & bus.operandoB;
            OP_OR:   unicoRes = bus.operandoA | bus.operandoB;
            OP_XOR:  unicoRes = bus.operandoA ^ bus.operandoB;
            OP_SLT:  unicoRes[0] = $signed(bus.operandoA) < $signed(bus.operandoB);
            OP_SLL:  unicoRes = bus.operandoA << bus.operandoB[4:0];
            OP_SRL:  unicoRes = bus.operandoA >> bus.operandoB[4:0];
            OP_DIVU: unicoRes = '1;
            OP_REMU: unicoRes = bus.operandoA;
            default: unicoRes = '0;
        endcase
    end

    // One radix-2 iteration of each algorithm. Multiply adds the multiplicand
    // into the upper half when the current multiplier bit is set, then shifts
    // the whole pair right. Divide shifts {resto, quociente} left and keeps
    // the trial subtraction when it does not borrow.
    always_comb begin
        mulSoma  = {1'b0, acc_q[2*LARGURA-1:LARGURA]} + (acc_q[0] ? {1'b0, opB_q} : '0);
        mulPasso = {mulSoma, acc_q[LARGURA-1:1]};
        divTopo  = acc_q[2*LARGURA-1:LARGURA-1];
        divTeste = divTopo - {1'b0, opB_q};
        divPasso = divTeste[LARGURA] ? {acc_q[2*LARGURA-2:0], 1'b0}
                                     : {divTeste[LARGURA-1:0], acc_q[LARGURA-2:0], 1'b1};
`ifdef ULA_MULH_EN
        ehMulEngine = (opCode_q == OP_MUL) || (opCode_q == OP_MULHU);
`else
        ehMulEngine = (opCode_q == OP_MUL);
`endif
    end

    // Pick which half of the engine register is the answer for the latched op.
    always_comb begin
        finalRes = '0;
        case (opCode_q)
            OP_MUL:   finalRes = acc_q[LARGURA-1:0];
            OP_DIVU:  finalRes = acc_q[LARGURA-1:0];
            OP_REMU:  finalRes = acc_q[2*LARGURA-1:LARGURA];
`ifdef ULA_MULH_EN
            OP_MULHU: finalRes = acc_q[2*LARGURA-1:LARGURA];
`endif
            default:  finalRes = '0;
        endcase
    end

    // Next-state logic: IDLE accepts ops, CALC iterates LARGURA times,
    // FIM publishes the result. Flush abandons CALC/FIM without a pulse.
    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        acc_d       = acc_q;
        opB_d       = opB_q;
        opCode_d    = opCode_q;
        resultado_d = resultado_q;
        zero_d      = zero_q;
        resValido_d = 1'b0;
        divZero_d   = 1'b0;
        case (estado_q)
            IDLE: begin
                if (aceita) begin
                    if (ehMulti) begin
                        acc_d      = {{LARGURA{1'b0}}, bus.operandoA};
                        opB_d      = bus.operandoB;
                        opCode_d   = bus.opULA;
                        contador_d = CW'(LARGURA);
                        estado_d   = CALC;
                    end else begin
                        resultado_d = unicoRes;
                        zero_d      = (unicoRes == '0);
                        resValido_d = 1'b1;
                        divZero_d   = ehDivisao && bZero;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    estado_d = IDLE;
                end else begin
                    acc_d      = ehMulEngine ? mulPasso : divPasso;
                    contador_d = contador_q - CW'(1);
                    if (contador_q == CW'(1)) begin
                        estado_d = FIM;
                    end
                end
            end
            FIM: begin
                estado_d = IDLE;
                if (!bus.flush) begin
                    resultado_d = finalRes;
                    zero_d      = (finalRes == '0);
                    resValido_d = 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // State and output registers; reset leaves zero high to match resultado = 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= IDLE;
            contador_q  <= '0;
            acc_q       <= '0;
            opB_q       <= '0;
            opCode_q    <= '0;
            resultado_q <= '0;
            resValido_q <= 1'b0;
            zero_q      <= 1'b1;
            divZero_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            acc_q       <= acc_d;
            opB_q       <= opB_d;
            opCode_q    <= opCode_d;
            resultado_q <= resultado_d;
            resValido_q <= resValido_d;
            zero_q      <= zero_d;
            divZero_q   <= divZero_d;
        end
    end

    // Stall is raised in the issue cycle of a multi-cycle op, before the FSM
    // has left IDLE, so the PC and hazard unit freeze immediately.
    assign bus.ocupado         = reset_n && ((estado_q != IDLE) || (bus.valido && ehMulti && !bus.flush));
    assign bus.resultado       = resultado_q;
    assign bus.resultadoValido = resValido_q;
    assign bus.zero            = zero_q;
    assign bus.divPorZero      = divZero_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_ula_multiciclo
// Directed testbench for ula_multiciclo: reset values, single-cycle ops,
// multiply/divide latency and stall, divide by zero, flush and mid-op reset.
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ula_multiciclo;
    localparam int L = 32;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_REMU  = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    ula_multiciclo_if #(.LARGURA(L)) bus ();

    ula_multiciclo #(.LARGURA(L)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    // Issues a multi-cycle op at a falling edge and watches until the result
    // pulse (bounded). Returns observations only; callers do the comparing.
    task automatic runMulti(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int edges, output int busy,
                            output logic issueBusy, output logic dz, output logic busyAtPulse);
        int pulses;
        @(negedge clock);
        bus.opULA = op; bus.operandoA = a; bus.operandoB = b;
        bus.valido = 1'b1; bus.flush = 1'b0;
        #1 issueBusy = bus.ocupado;
        edges = 0; busy = 0; pulses = 0; res = '0; dz = 1'b0; busyAtPulse = 1'b1;
        while (pulses == 0 && edges < 60) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (bus.resultadoValido) begin
                pulses++;
                res = bus.resultado;
                dz = bus.divPorZero;
                busyAtPulse = bus.ocupado;
            end else if (bus.ocupado) begin
                busy++;
            end
            if (edges == 1) begin
                // Scramble inputs after acceptance; the engine must use its latched copies.
                bus.valido = 1'b0; bus.opULA = OP_ADD;
                bus.operandoA = 32'hDEAD_BEEF; bus.operandoB = 32'h0000_0001;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.opULA = OP_MUL; bus.operandoA = 32'h3; bus.operandoB = 32'h5;
        bus.valido = 1'b1; bus.flush = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (bus.resultado !== 32'h0) begin errors++; $display("[TB] FAIL reset_resultado: got %h expected %h", bus.resultado, 32'h0); end
        checks++; if (bus.resultadoValido !== 1'b0) begin errors++; $display("[TB] FAIL reset_valido: got %b expected 0", bus.resultadoValido); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero: got %b expected 1", bus.zero); end
        checks++; if (bus.divPorZero !== 1'b0) begin errors++; $display("[TB] FAIL reset_divPorZero: got %b expected 0", bus.divPorZero); end
        checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL reset_ocupado: got %b expected 0", bus.ocupado); end
        bus.valido = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.ocupado !== 1'b0 || bus.resultadoValido !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: got ocupado=%b valido=%b expected 0/0", bus.ocupado, bus.resultadoValido); end
    endtask

    task automatic test_single();
        logic [3:0]  ops [11];
        logic [31:0] as  [11];
        logic [31:0] bs  [11];
        logic [31:0] exps[11];
        ops  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLT, OP_SLL, OP_SRL, 4'd12, 4'd15};
        as   = '{32'h7FFF_FFFF, 32'h5, 32'hF0F0_FF00, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FFFF,
                 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        bs   = '{32'h0000_0001, 32'h5, 32'h0FF0_F0F0, 32'h0000_000F, 32'h0F0F_0F0F, 32'h0000_0001,
                 32'hFFFF_FFFF, 32'h0000_0024, 32'h0000_001F, 32'h1111_1111, 32'hFFFF_FFFF};
        exps = '{32'h8000_0000, 32'h0, 32'h00F0_F000, 32'hF000_000F, 32'hF0F0_0F0F, 32'h1,
                 32'h0, 32'h0000_0010, 32'h0000_0001, 32'h0, 32'h0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            bus.opULA = ops[i]; bus.operandoA = as[i]; bus.operandoB = bs[i]; bus.valido = 1'b1;
            #1;
            checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL single_ocupado[%0d]: got %b expected 0", i, bus.ocupado); end
            @(negedge clock);
            checks++; if (bus.resultado !== exps[i]) begin errors++; $display("[TB] FAIL single_resultado[%0d]: got %h expected %h", i, bus.resultado, exps[i]); end
            checks++; if (bus.resultadoValido !== 1'b1) begin errors++; $display("[TB] FAIL single_valido[%0d]: got %b expected 1", i, bus.resultadoValido); end
            checks++; if (bus.zero !== (exps[i] == 32'h0)) begin errors++; $display("[TB] FAIL single_zero[%0d]: got %b expected %b", i, bus.zero, (exps[i] == 32'h0)); end
            checks++; if (bus.divPorZero !== 1'b0) begin errors++; $display("[TB] FAIL single_divPorZero[%0d]: got %b expected 0", i, bus.divPorZero); end
            bus.valido = 1'b0;
            @(negedge clock);
            checks++; if (bus.resultadoValido !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width[%0d]: got %b expected 0", i, bus.resultadoValido); end
        end
`ifndef ULA_MULH_EN
        // Without MULHU, opcode 11 is a single-cycle zero.
        @(negedge clock);
        bus.opULA = OP_MULHU; bus.operandoA = 32'hFFFF_FFFF; bus.operandoB = 32'hFFFF_FFFF; bus.valido = 1'b1;
        #1;
        checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL op11_ocupado: got %b expected 0", bus.ocupado); end
        @(negedge clock);
        checks++; if (bus.resultado !== 32'h0 || bus.resultadoValido !== 1'b1) begin errors++; $display("[TB] FAIL op11_result: got %h/%b expected 00000000/1", bus.resultado, bus.resultadoValido); end
        bus.valido = 1'b0;
`endif
    endtask

    task automatic test_mul();
        logic [31:0] res; int edges; int busy; logic ib; logic dz; logic bp;
        runMulti(OP_MUL, 32'h0001_0003, 32'h0000_0005, res, edges, busy, ib, dz, bp);
        checks++; if (ib !== 1'b1) begin errors++; $display("[TB] FAIL mul_issue_ocupado: got %b expected 1", ib); end
        checks++; if (edges != 34) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 34", edges); end
        checks++; if (busy != 33) begin errors++; $display("[TB] FAIL mul_busy_cycles: got %0d expected 33", busy); end
        checks++; if (res !== 32'h0005_000F) begin errors++; $display("[TB] FAIL mul_resultado: got %h expected %h", res, 32'h0005_000F); end
        checks++; if (bp !== 1'b0) begin errors++; $display("[TB] FAIL mul_ocupado_at_pulse: got %b expected 0", bp); end
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("[TB] FAIL mul_zero: got %b expected 0", bus.zero); end
        // Back-to-back: an ADD issued in the pulse cycle completes on the next edge.
        bus.opULA = OP_ADD; bus.operandoA = 32'h1; bus.operandoB = 32'h2; bus.valido = 1'b1;
        @(negedge clock);
        checks++; if (bus.resultado !== 32'h3 || bus.resultadoValido !== 1'b1) begin errors++; $display("[TB] FAIL back_to_back_add: got %h/%b expected 00000003/1", bus.resultado, bus.resultadoValido); end
        bus.valido = 1'b0;
`ifdef ULA_MULH_EN
        runMulti(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, edges, busy, ib, dz, bp);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mulhu_resultado: got %h expected %h", res, 32'hFFFF_FFFE); end
        checks++; if (edges != 34) begin errors++; $display("[TB] FAIL mulhu_latency: got %0d expected 34", edges); end
`endif
    endtask

    task automatic test_div();
        logic [31:0] res; int edges; int busy; logic ib; logic dz; logic bp;
        runMulti(OP_DIVU, 32'd100, 32'd7, res, edges, busy, ib, dz, bp);
        checks++; if (res !== 32'd14) begin errors++; $display("[TB] FAIL divu_resultado: got %h expected %h", res, 32'd14); end
        checks++; if (edges != 34 || busy != 33) begin errors++; $display("[TB] FAIL divu_timing: got edges=%0d busy=%0d expected 34/33", edges, busy); end
        checks++; if (dz !== 1'b0) begin errors++; $display("[TB] FAIL divu_divPorZero: got %b expected 0", dz); end
        @(negedge clock);
        checks++; if (bus.resultadoValido !== 1'b0) begin errors++; $display("[TB] FAIL divu_pulse_width: got %b expected 0", bus.resultadoValido); end
        runMulti(OP_REMU, 32'd100, 32'd7, res, edges, busy, ib, dz, bp);
        checks++; if (res !== 32'd2) begin errors++; $display("[TB] FAIL remu_resultado: got %h expected %h", res, 32'd2); end
        runMulti(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, res, edges, busy, ib, dz, bp);
        checks++; if (res !== 32'h0FFF_FFFF) begin errors++; $display("[TB] FAIL divu_large: got %h expected %h", res, 32'h0FFF_FFFF); end
        runMulti(OP_REMU, 32'd6, 32'd3, res, edges, busy, ib, dz, bp);
        checks++; if (res !== 32'd0 || bus.zero !== 1'b1) begin errors++; $display("[TB] FAIL remu_zero: got %h/zero=%b expected 00000000/1", res, bus.zero); end
    endtask

    task automatic test_divzero();
        @(negedge clock);
        bus.opULA = OP_DIVU; bus.operandoA = 32'd100; bus.operandoB = 32'd0; bus.valido = 1'b1;
        #1;
        checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL div0_ocupado: got %b expected 0", bus.ocupado); end
        @(negedge clock);
        checks++; if (bus.resultado !== 32'hFFFF_FFFF || bus.resultadoValido !== 1'b1) begin errors++; $display("[TB] FAIL div0_divu: got %h/%b expected ffffffff/1", bus.resultado, bus.resultadoValido); end
        checks++; if (bus.divPorZero !== 1'b1) begin errors++; $display("[TB] FAIL div0_flag: got %b expected 1", bus.divPorZero); end
        checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL div0_ocupado_after: got %b expected 0", bus.ocupado); end
        bus.opULA = OP_REMU; bus.operandoA = 32'h0000_1234;
        @(negedge clock);
        checks++; if (bus.resultado !== 32'h0000_1234 || bus.divPorZero !== 1'b1) begin errors++; $display("[TB] FAIL div0_remu: got %h/%b expected 00001234/1", bus.resultado, bus.divPorZero); end
        bus.valido = 1'b0;
        @(negedge clock);
        checks++; if (bus.divPorZero !== 1'b0 || bus.resultadoValido !== 1'b0) begin errors++; $display("[TB] FAIL div0_pulse_width: got %b/%b expected 0/0", bus.divPorZero, bus.resultadoValido); end
    endtask

    task automatic test_flush();
        int pulses;
        // Known result to check it is preserved across the flush.
        @(negedge clock);
        bus.opULA = OP_ADD; bus.operandoA = 32'h11; bus.operandoB = 32'h22; bus.valido = 1'b1; bus.flush = 1'b0;
        @(negedge clock);
        checks++; if (bus.resultado !== 32'h33) begin errors++; $display("[TB] FAIL flush_setup: got %h expected %h", bus.resultado, 32'h33); end
        bus.opULA = OP_MUL; bus.operandoA = 32'h0001_0003; bus.operandoB = 32'h5;
        @(negedge clock);
        bus.valido = 1'b0;
        repeat (10) @(negedge clock);
        checks++; if (bus.ocupado !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_calc: got %b expected 1", bus.ocupado); end
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL flush_ocupado: got %b expected 0", bus.ocupado); end
        checks++; if (bus.resultado !== 32'h33) begin errors++; $display("[TB] FAIL flush_resultado_kept: got %h expected %h", bus.resultado, 32'h33); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.resultadoValido === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL flush_no_pulse: got %0d expected 0", pulses); end
        bus.opULA = OP_ADD; bus.operandoA = 32'h2; bus.operandoB = 32'h3; bus.valido = 1'b1;
        @(negedge clock);
        checks++; if (bus.resultado !== 32'h5 || bus.resultadoValido !== 1'b1) begin errors++; $display("[TB] FAIL flush_then_add: got %h/%b expected 00000005/1", bus.resultado, bus.resultadoValido); end
        // Flush together with valido in IDLE: not accepted.
        bus.opULA = OP_MUL; bus.flush = 1'b1;
        #1;
        checks++; if (bus.ocupado !== 1'b0) begin errors++; $display("[TB] FAIL flush_issue_ocupado: got %b expected 0", bus.ocupado); end
        @(negedge clock);
        bus.valido = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.ocupado !== 1'b0 || bus.resultadoValido !== 1'b0) begin errors++; $display("[TB] FAIL flush_issue_rejected: got ocupado=%b valido=%b expected 0/0", bus.ocupado, bus.resultadoValido); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int busyCycles;
        @(negedge clock);
        bus.opULA = OP_DIVU; bus.operandoA = 32'd100; bus.operandoB = 32'd7; bus.valido = 1'b1; bus.flush = 1'b0;
        @(negedge clock);
        bus.valido = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.resultado !== 32'h0 || bus.zero !== 1'b1) begin errors++; $display("[TB] FAIL midreset_outputs: got %h/zero=%b expected 00000000/1", bus.resultado, bus.zero); end
        checks++; if (bus.ocupado !== 1'b0 || bus.resultadoValido !== 1'b0 || bus.divPorZero !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got %b%b%b expected 000", bus.ocupado, bus.resultadoValido, bus.divPorZero); end
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0; busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.resultadoValido === 1'b1) pulses++;
            if (bus.ocupado === 1'b1) busyCycles++;
        end
        checks++; if (pulses != 0 || busyCycles != 0) begin errors++; $display("[TB] FAIL midreset_stale: got pulses=%0d busy=%0d expected 0/0", pulses, busyCycles); end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_divzero();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- EX-stage ALU fed directly by the forwarding multiplexers: operandoA comes from the A-side forward mux, operandoB from muxForwardB.
- Single-cycle ops produce a registered result one clock after issue.
- MUL/DIVU/REMU run in an iterative radix-2 engine (shift-add / restoring divide) and stall the pipeline through ocupado.
- Output registers feed the EX/MEM pipeline register.

Parameters:
- LARGURA, 32, datapath width in bits; counter width is clog2(LARGURA)+1.

Ports:
- clock  input  1  pipeline clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- operandoA  input  LARGURA  first operand (forwarded rs1 value)
- operandoB  input  LARGURA  second operand (forwarded rs2 value or immediate)
- opULA  input  4  operation select
- valido  input  1  issue strobe; the op is present this cycle
- flush  input  1  kill the in-flight op (branch mispredict / exception)
- resultado  output  LARGURA  registered result
- resultadoValido  output  1  one-cycle pulse; resultado holds a new value
- zero  output  1  registered, (resultado == 0), updated with resultado
- divPorZero  output  1  one-cycle pulse with resultadoValido on DIVU/REMU with operandoB == 0
- ocupado  output  1  combinational stall request to the hazard unit and PC

Behaviour:
- Reset (reset_n = 0, asynchronous) sets resultado = 0, resultadoValido = 0, zero = 1, divPorZero = 0, state IDLE, counter = 0, and engine registers = 0. ocupado is 0 during reset.
- Reset asserted mid-operation discards the op with no result pulse.
- opULA encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT (signed, result 1 or 0)
  - 6 SLL, 7 SRL (shift amount = operandoB[4:0], logical)
  - 8 MUL (low LARGURA bits), 9 DIVU, 10 REMU
  - 11 to 15 give resultado = 0 with single-cycle latency (see optional feature for 11).
- Arithmetic wraps modulo 2^LARGURA; there are no overflow flags.
- Single-cycle ops and divide-by-zero:
  - Accepted on an edge where state = IDLE, valido = 1 and flush = 0.
  - resultado, zero and a resultadoValido pulse appear after that same edge (latency 1).
  - Divide-by-zero is taken on this path: DIVU gives all-ones, REMU gives operandoA, and divPorZero pulses.
- Multi-cycle ops (MUL, DIVU/REMU with operandoB != 0):
  - State machine: IDLE -> CALC -> FIM -> IDLE.
  - Issue edge T0: operands are latched, counter = LARGURA, state goes to CALC.
  - CALC: one iteration per edge, counter decrements; at counter == 1 the next edge goes to FIM.
  - FIM: the result is written; resultadoValido pulses in the cycle after the FIM edge; state returns to IDLE.
  - Total result latency is LARGURA+2 edges after T0 (34 for LARGURA = 32).
- ocupado = (state != IDLE) OR (valido AND op is multi-cycle AND NOT flush).
  - Upstream holds the instruction and operands stable while ocupado = 1.
  - ocupado drops in the cycle the result pulse is visible, so the next op can issue on that edge.
- Inputs are ignored while state != IDLE.
- Latched operands are used inside the engine, so operand changes mid-CALC have no effect.
- flush:
  - In CALC or FIM, flush returns the state to IDLE on the next edge with no resultadoValido; resultado keeps its previous value.
  - Flush together with valido in IDLE means the op is not accepted.
- resultadoValido and divPorZero are never high for more than one consecutive cycle per op.

Optional Feature:
- Macro ULA_MULH_EN.
- Defined: opULA 11 = MULHU, the upper LARGURA bits of the unsigned product. It uses the multi-cycle path with the same latency as MUL and the same engine; the product register is 2*LARGURA wide.
- Undefined: opULA 11 behaves like 12 to 15 (result 0, single-cycle). The product high half may be trimmed if synthesis allows.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 with valido for 1 cycle -> next cycle resultado = 0x80000000, resultadoValido = 1, zero = 0, ocupado always 0. SUB 5 - 5 -> resultado = 0, zero = 1.
- SLT signed: A = 0xFFFFFFFF, B = 0x00000001 -> resultado = 1. SLL A = 0x1, B = 0x00000024 (shamt 4) -> resultado = 0x10.
- MUL 0x0001_0003 x 0x0000_0005 -> ocupado = 1 in the issue cycle and for 33 following cycles; resultado = 0x0005_000F exactly 34 edges after issue; a single resultadoValido pulse. With ULA_MULH_EN, MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 100 / 7 -> resultado = 14; REMU -> 2. DIVU 100 / 0 -> latency 1, resultado = 0xFFFFFFFF, divPorZero = 1, ocupado never asserted.
- MUL issued, flush pulsed at cycle 10 of CALC -> ocupado = 0 on the next cycle, no resultadoValido, resultado unchanged. An ADD issued immediately after completes normally.
- DIVU in CALC, reset_n pulsed low mid-cycle -> all outputs go to their reset values immediately (zero = 1). After release, ocupado = 0 and no stale result pulse appears.
